// File: rtl/bus_responder.sv
// Memory-side bus responder: services CPU read/write requests against an
// async SRAM/ROM port with programmable wait states and ROM write blocking.
module bus_responder #(
  parameter int unsigned     WAIT_STATES = 2,
  parameter logic [7:0]      FAST_PAGE   = 8'h00,
  parameter logic [15:0]     ROM_BASE    = 16'hE000
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        wr_err
);

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic        fast_hit;
  logic        rom_hit;

  assign fast_hit = (cpu_addr[15:8] == FAST_PAGE);
  assign rom_hit  = (cpu_addr >= ROM_BASE);

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      rdata_q <= 8'h00;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      ce_q    <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ce_d    = ce_q;
    oe_d    = oe_q;
    we_d    = we_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          cnt_d   = fast_hit ? 4'd0 : WS;
          ce_d    = 1'b1;
          oe_d    = cpu_rw;
          we_d    = ~cpu_rw & ~rom_hit;
          ready_d = 1'b0;
          state_d = ACCESS;
          // ROM writes still run the full cycle, just without a strobe
          if (!cpu_rw && rom_hit) begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (oe_q) begin
            rdata_d = mem_rdata;
          end
          ce_d    = 1'b0;
          oe_d    = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ce    = ce_q;
  assign mem_oe    = oe_q;
  assign mem_we    = we_q;
  assign wr_err    = err_q;

endmodule
